// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates from an incoming
// active-low h/v sync pair, measures line length and reports phase faults once locked.
module vga_sync_rx #(
   parameter int BIT          = 10,
   parameter int HRES         = 640,
   parameter int VRES         = 480,
   parameter int H_TOTAL      = 800,
   parameter int V_TOTAL      = 525,
   parameter int H_SYNC_START = 655,
   parameter int V_SYNC_START = 489,
   parameter int LOCK_LINES   = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           h_sync_in,
   input  logic           v_sync_in,
   output logic [BIT-1:0] x_pos,
   output logic [BIT-1:0] y_pos,
   output logic           active,
   output logic           locked,
   output logic           h_err,
   output logic           v_err,
   output logic [BIT-1:0] line_len
);

   localparam logic [BIT-1:0] ONE    = BIT'(1);
   localparam logic [BIT-1:0] X_LAST = BIT'(H_TOTAL - 1);
   localparam logic [BIT-1:0] Y_LAST = BIT'(V_TOTAL - 1);
   localparam logic [BIT-1:0] X_SYNC = BIT'(H_SYNC_START);
   localparam logic [BIT-1:0] X_LOAD = BIT'(H_SYNC_START + 1);
   localparam logic [BIT-1:0] Y_SYNC = BIT'(V_SYNC_START);
   localparam logic [BIT-1:0] H_ACT  = BIT'(HRES);
   localparam logic [BIT-1:0] V_ACT  = BIT'(VRES);
   localparam logic [BIT-1:0] H_LEN  = BIT'(H_TOTAL);
   localparam logic [3:0]     LOCK_N = 4'(LOCK_LINES);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      HLOCK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t         state;
   logic           h_q;
   logic           v_q;
   logic [BIT-1:0] x_cnt;
   logic [BIT-1:0] y_cnt;
   logic [BIT-1:0] per_cnt;
   logic [3:0]     good;

   logic           h_fe;
   logic           v_fe;
   logic           x_match;
   logic           y_match;
   logic [BIT-1:0] per_inc;
   logic           good_line;
   logic           x_load;
   logic           y_load;
   logic           x_wrap;
   logic           h_fault;
   logic           v_fault;
   logic [3:0]     good_nxt;

   // Edge detection, alignment decisions and fault classification
   always_comb begin
      h_fe      = h_q & ~h_sync_in;
      v_fe      = v_q & ~v_sync_in;
      x_match   = (x_cnt == X_SYNC);
      y_match   = (y_cnt == Y_SYNC);
      per_inc   = (per_cnt == '1) ? per_cnt : per_cnt + ONE;
      good_line = h_fe && (per_inc == H_LEN);
      x_load    = h_fe && !x_match;
      y_load    = v_fe && !y_match;
      x_wrap    = (x_cnt == X_LAST) && !x_load;
      h_fault   = (h_fe && !x_match) || (x_match && !h_fe) || (h_fe && !good_line);
      v_fault   = (v_fe && !y_match) || (x_match && y_match && v_sync_in);
      good_nxt  = good + 4'd1;
   end

   // Sync history, coordinate counters and line-period measurement
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q      <= 1'b1;
         v_q      <= 1'b1;
         x_cnt    <= '0;
         y_cnt    <= '0;
         per_cnt  <= '1;
         line_len <= '0;
      end else begin
         h_q <= h_sync_in;
         v_q <= v_sync_in;
         if (x_load) begin
            x_cnt <= X_LOAD;
         end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
         end else begin
            x_cnt <= x_cnt + ONE;
         end
         // A vertical realignment wins over the line-wrap increment
         if (y_load) begin
            y_cnt <= Y_SYNC;
         end else if (x_wrap) begin
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + ONE;
         end else begin
            y_cnt <= y_cnt;
         end
         if (h_fe) begin
            line_len <= per_inc;
            per_cnt  <= '0;
         end else begin
            per_cnt  <= per_inc;
         end
      end
   end

   // Lock state machine with registered lock flag and error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= SEARCH;
         good   <= 4'd0;
         locked <= 1'b0;
         h_err  <= 1'b0;
         v_err  <= 1'b0;
      end else begin
         h_err <= 1'b0;
         v_err <= 1'b0;
         case (state)
            SEARCH: begin
               locked <= 1'b0;
               if (h_fe) begin
                  if (!good_line) begin
                     good <= 4'd0;
                  end else if (good_nxt == LOCK_N) begin
                     state <= HLOCK;
                     good  <= 4'd0;
                  end else begin
                     good <= good_nxt;
                  end
               end
            end
            HLOCK: begin
               if (h_fe && (!x_match || !good_line)) begin
                  state  <= SEARCH;
                  good   <= 4'd0;
                  locked <= 1'b0;
               end else if (v_fe) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (h_fault || v_fault) begin
                  state  <= SEARCH;
                  good   <= 4'd0;
                  locked <= 1'b0;
                  h_err  <= h_fault;
                  v_err  <= v_fault;
               end
            end
            default: begin
               state  <= SEARCH;
               good   <= 4'd0;
               locked <= 1'b0;
            end
         endcase
      end
   end

   assign x_pos  = x_cnt;
   assign y_pos  = y_cnt;
   assign active = locked && (x_cnt < H_ACT) && (y_cnt < V_ACT);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a shrunken 40x16 raster so that several
// frames of acquisition, fault and relock fit in a short run.
module tb_vga_sync_rx;

   localparam int BIT = 10;
   localparam int HT  = 40;
   localparam int VT  = 16;
   localparam int HSS = 34;
   localparam int VSS = 13;

   logic           clk = 1'b0;
   logic           reset;
   logic           h_sync_in;
   logic           v_sync_in;
   logic [BIT-1:0] x_pos;
   logic [BIT-1:0] y_pos;
   logic           active;
   logic           locked;
   logic           h_err;
   logic           v_err;
   logic [BIT-1:0] line_len;

   vga_sync_rx #(
      .BIT(BIT), .HRES(32), .VRES(12), .H_TOTAL(HT), .V_TOTAL(VT),
      .H_SYNC_START(HSS), .V_SYNC_START(VSS), .LOCK_LINES(4)
   ) dut (
      .clk(clk), .reset(reset), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .x_pos(x_pos), .y_pos(y_pos), .active(active), .locked(locked),
      .h_err(h_err), .v_err(v_err), .line_len(line_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sx; int sy;
      int x;  int y; int act; int lk; int ll; int he; int ve;
   } vec_t;

   vec_t tbl[10];
   int   errors = 0;
   int   checks = 0;
   int   sx = 0;
   int   sy = 0;
   int   kill_line = -1;
   int   v_shift = 0;
   int   herr_seen = 0;
   int   verr_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (src x=%0d y=%0d)", name, act, exp, sx, sy);
      end
   endtask

   // Source raster: h low for x 34..37, v low for lines 13..14 (optionally shifted)
   task automatic drive();
      int vy;
      vy = (sy - v_shift + VT) % VT;
      h_sync_in = !((sx >= HSS) && (sx <= HSS + 3) && (sy != kill_line));
      v_sync_in = !((vy == VSS) || (vy == VSS + 1));
   endtask

   task automatic tick(input int adv);
      @(posedge clk);
      #1;
      if (h_err) herr_seen++;
      if (v_err) verr_seen++;
      sx += adv;
      if (sx >= HT) begin
         sx -= HT;
         sy = (sy + 1) % VT;
      end
      drive();
   endtask

   task automatic goto_pos(input int x, input int y);
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!(sx == x && sy == y) && n < 3000);
      if (!(sx == x && sy == y)) begin
         checks++;
         errors++;
         $display("FAIL goto: reached (%0d,%0d) required (%0d,%0d)", sx, sy, x, y);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hb;
      int vb;
      tbl[0] = '{35,  3, 35,  0, 0, 0, 1023, 0, 0};
      tbl[1] = '{35,  4, 35,  1, 0, 0,   40, 0, 0};
      tbl[2] = '{ 0, 13,  0, 10, 0, 0,   40, 0, 0};
      tbl[3] = '{ 1, 13,  1, 13, 0, 1,   40, 0, 0};
      tbl[4] = '{39, 15, 39, 15, 0, 1,   40, 0, 0};
      tbl[5] = '{ 0,  0,  0,  0, 1, 1,   40, 0, 0};
      tbl[6] = '{31, 11, 31, 11, 1, 1,   40, 0, 0};
      tbl[7] = '{32, 11, 32, 11, 0, 1,   40, 0, 0};
      tbl[8] = '{ 0, 12,  0, 12, 0, 1,   40, 0, 0};
      tbl[9] = '{35, 13, 35, 13, 0, 1,   40, 0, 0};

      // Reset with arbitrary sync activity
      reset = 1'b1;
      h_sync_in = 1'b0;
      v_sync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         h_sync_in = 1'($urandom_range(0, 1));
         v_sync_in = 1'($urandom_range(0, 1));
      end
      chk("rst.x_pos", int'(x_pos), 0);
      chk("rst.y_pos", int'(y_pos), 0);
      chk("rst.active", int'(active), 0);
      chk("rst.locked", int'(locked), 0);
      chk("rst.h_err", int'(h_err), 0);
      chk("rst.v_err", int'(v_err), 0);
      chk("rst.line_len", int'(line_len), 0);
      sx = 5;
      sy = 3;
      drive();
      reset = 1'b0;

      // Clean acquisition and frame checkpoints
      for (int i = 0; i < 10; i++) begin
         goto_pos(tbl[i].sx, tbl[i].sy);
         chk($sformatf("vec%0d.x_pos", i), int'(x_pos), tbl[i].x);
         chk($sformatf("vec%0d.y_pos", i), int'(y_pos), tbl[i].y);
         chk($sformatf("vec%0d.active", i), int'(active), tbl[i].act);
         chk($sformatf("vec%0d.locked", i), int'(locked), tbl[i].lk);
         chk($sformatf("vec%0d.line_len", i), int'(line_len), tbl[i].ll);
         chk($sformatf("vec%0d.h_err", i), int'(h_err), tbl[i].he);
         chk($sformatf("vec%0d.v_err", i), int'(v_err), tbl[i].ve);
      end

      // Phase jump: source stalls 3 clocks mid-line
      goto_pos(10, 2);
      hb = herr_seen;
      vb = verr_seen;
      repeat (3) tick(0);
      goto_pos(31, 2);
      chk("pj.x_ahead", int'(x_pos), 34);
      chk("pj.pre_locked", int'(locked), 1);
      chk("pj.pre_h_err", int'(h_err), 0);
      tick(1);
      chk("pj.h_err", int'(h_err), 1);
      chk("pj.locked_drop", int'(locked), 0);
      tick(1);
      chk("pj.h_err_end", int'(h_err), 0);
      goto_pos(35, 2);
      chk("pj.x_reload", int'(x_pos), 35);
      goto_pos(39, 2);
      chk("pj.h_pulses", herr_seen - hb, 1);
      chk("pj.v_pulses", verr_seen - vb, 0);
      goto_pos(0, 13);
      chk("pj.relock_pre", int'(locked), 0);
      tick(1);
      chk("pj.relock", int'(locked), 1);
      chk("pj.relock_x", int'(x_pos), 1);
      chk("pj.relock_y", int'(y_pos), 13);

      // Missing h pulse on line 3 of the next frame
      kill_line = 3;
      goto_pos(34, 3);
      chk("mh.pre_locked", int'(locked), 1);
      chk("mh.pre_h_err", int'(h_err), 0);
      tick(1);
      chk("mh.h_err", int'(h_err), 1);
      chk("mh.locked_drop", int'(locked), 0);
      chk("mh.v_err", int'(v_err), 0);
      tick(1);
      chk("mh.h_err_end", int'(h_err), 0);
      goto_pos(35, 4);
      kill_line = -1;
      chk("mh.line_len", int'(line_len), 80);

      // Short line after three good lines while searching
      goto_pos(10, 8);
      tick(2);
      goto_pos(35, 8);
      chk("bl.line_len", int'(line_len), 39);
      chk("bl.x_realign", int'(x_pos), 35);
      chk("bl.locked", int'(locked), 0);
      goto_pos(35, 9);
      chk("bl.line_len_good", int'(line_len), 40);
      goto_pos(0, 13);
      chk("bl.relock_pre", int'(locked), 0);
      tick(1);
      chk("bl.relock", int'(locked), 1);

      // Vertical sync delayed by one line
      goto_pos(0, 0);
      v_shift = 1;
      drive();
      hb = herr_seen;
      vb = verr_seen;
      goto_pos(34, 13);
      chk("vf.pre_locked", int'(locked), 1);
      chk("vf.pre_v_err", int'(v_err), 0);
      tick(1);
      chk("vf.v_err", int'(v_err), 1);
      chk("vf.locked_drop", int'(locked), 0);
      chk("vf.h_err", int'(h_err), 0);
      tick(1);
      chk("vf.v_err_end", int'(v_err), 0);
      goto_pos(0, 14);
      chk("vf.y_before", int'(y_pos), 14);
      tick(1);
      chk("vf.y_reload", int'(y_pos), 13);
      chk("vf.h_pulses", herr_seen - hb, 0);
      chk("vf.v_pulses", verr_seen - vb, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
